output_port_sink: RTL

//  Consumer side of the processor output port. Captures every byte the core strobes out with

---
 rtl/io_port_pkg.sv | 27 ++
 rtl/output_port_sink_if.sv | 45 ++++
 rtl/port_sink_fifo_mem.sv | 36 +++
 rtl/output_port_sink.sv | 107 ++++++++++
 4 files changed

// File: rtl/io_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : io_port_pkg
//  Brief   : Shared constants, byte type and sizing helper for the output port.
//  Revision: 1.0  initial release
// ============================================================================
package io_port_pkg;

    localparam int PORT_DATA_W     = 8;
    localparam int PORT_FIFO_DEPTH = 4;

    typedef logic [PORT_DATA_W-1:0] port_byte_t;

    // Smallest w with 2**w >= depth; depth is expected to be a power of two.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < depth) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_sink_if.sv
`default_nettype none
// ============================================================================
//  Module  : output_port_sink_if
//  Brief   : Core write strobe, downstream valid/ready stream and status flags.
//            PORT_SINK_PARITY_EN widens m_data by one parity bit.
//  Revision: 1.0  initial release
// ============================================================================
interface output_port_sink_if
    import io_port_pkg::*;
#(
    parameter int DATA_W = PORT_DATA_W,
    parameter int DEPTH  = PORT_FIFO_DEPTH
) ();

    localparam int ADDR_W = clog2_depth(DEPTH);
`ifdef PORT_SINK_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic                m_valid;
    logic                m_ready;
    logic [ENTRY_W-1:0]  m_data;
    logic [DATA_W-1:0]   last_data;
    logic [ADDR_W:0]     count;
    logic                full;
    logic                overflow;
    logic                ovf_clr;

    // master: the sink itself; slave: the core plus downstream consumer
    modport master (
        input  wr_en, wr_data, m_ready, ovf_clr,
        output m_valid, m_data, last_data, count, full, overflow
    );

    modport slave (
        output wr_en, wr_data, m_ready, ovf_clr,
        input  m_valid, m_data, last_data, count, full, overflow
    );

endinterface
`default_nettype wire

// File: rtl/port_sink_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module  : port_sink_fifo_mem
//  Brief   : DEPTH x WIDTH register array, one write port, asynchronous read.
//  Revision: 1.0  initial release
// ============================================================================
module port_sink_fifo_mem #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [WIDTH-1:0]  wdata,
    input  wire logic [ADDR_W-1:0] raddr,
    output logic      [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/output_port_sink.sv
`default_nettype none
// ============================================================================
//  Module  : output_port_sink
//  Brief   : FWFT FIFO capturing core output-port bytes, drained by valid/ready;
//            writes into a full FIFO are dropped and flagged. PORT_SINK_PARITY_EN
//            stores an even-parity bit with each byte.
//  Revision: 1.0  initial release
// ============================================================================
module output_port_sink
    import io_port_pkg::*;
#(
    parameter int DATA_W = PORT_DATA_W,
    parameter int DEPTH  = PORT_FIFO_DEPTH
) (
    input  wire logic           clk,
    input  wire logic           rst,
    output_port_sink_if.master  port
);

    localparam int ADDR_W = clog2_depth(DEPTH);
`ifdef PORT_SINK_PARITY_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif
    localparam logic [ADDR_W:0] c_PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W:0]    r_wr_ptr;
    logic [ADDR_W:0]    r_rd_ptr;
    logic [ADDR_W:0]    r_count;
    logic [DATA_W-1:0]  r_last_data;
    logic               r_overflow;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic [ENTRY_W-1:0] w_wdata;
    logic [ENTRY_W-1:0] w_rdata;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_pop   = ~w_empty & port.m_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = port.wr_en & (~w_full | w_pop);
    assign w_drop  = port.wr_en & w_full & ~w_pop;

`ifdef PORT_SINK_PARITY_EN
    assign w_wdata = {^port.wr_data, port.wr_data};
`else
    assign w_wdata = port.wr_data;
`endif

    port_sink_fifo_mem #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (w_push),
        .waddr (r_wr_ptr[ADDR_W-1:0]),
        .wdata (w_wdata),
        .raddr (r_rd_ptr[ADDR_W-1:0]),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr    <= r_wr_ptr + c_PTR_ONE;
                r_last_data <= port.wr_data;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_PTR_ONE;
                2'b01:   r_count <= r_count - c_PTR_ONE;
                default: r_count <= r_count;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (port.ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign port.m_valid   = ~w_empty;
    assign port.m_data    = w_rdata;
    assign port.last_data = r_last_data;
    assign port.count     = r_count;
    assign port.full      = w_full;
    assign port.overflow  = r_overflow;

endmodule
`default_nettype wire
